// File: rtl/op_seq_ctrl.sv
// Operation sequencer: issues a programmed number of operations over valid/ready,
// counts completions and reports raw idle/done status to the output-register stage.
module op_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_op_i,
    input  logic             abort_i,
    output logic             op_valid_o,
    input  logic             op_ready_i,
    output logic [CNT_W-1:0] op_idx_o,
    input  logic             op_done_i,
    output logic             idle_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] cmpl_cnt;

    logic             handshake;
    logic             last_issue;
    logic             cmpl_inc;
    logic [CNT_W-1:0] cmpl_next;
    logic             running;

    assign handshake  = op_valid_o && op_ready_i;
    assign last_issue = (issue_cnt == total - ONE);
    // Completion count saturates at total so stray pulses cannot overrun it.
    assign cmpl_inc   = op_done_i && (cmpl_cnt != total);
    assign cmpl_next  = cmpl_inc ? cmpl_cnt + ONE : cmpl_cnt;
    assign running    = (state == S_ISSUE) || (state == S_WAIT);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch below reads the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            total      <= '0;
            issue_cnt  <= '0;
            cmpl_cnt   <= '0;
            op_valid_o <= 1'b0;
            op_idx_o   <= '0;
            idle_o     <= 1'b1;
            done_o     <= 1'b0;
        end else if (running && abort_i) begin
            // Abort wins over any handshake or completion seen in the same cycle.
            state      <= S_IDLE;
            issue_cnt  <= '0;
            cmpl_cnt   <= '0;
            op_valid_o <= 1'b0;
            op_idx_o   <= '0;
            idle_o     <= 1'b1;
            done_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        idle_o <= 1'b0;
                        if (num_op_i != '0) begin
                            total      <= num_op_i;
                            issue_cnt  <= '0;
                            cmpl_cnt   <= '0;
                            op_valid_o <= 1'b1;
                            op_idx_o   <= '0;
                            state      <= S_ISSUE;
                        end else begin
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end

                S_ISSUE: begin
                    cmpl_cnt <= cmpl_next;
                    if (handshake) begin
                        issue_cnt <= issue_cnt + ONE;
                        if (last_issue) begin
                            op_valid_o <= 1'b0;
                            op_idx_o   <= '0;
                            state      <= S_WAIT;
                        end else begin
                            op_idx_o <= issue_cnt + ONE;
                        end
                    end
                end

                S_WAIT: begin
                    cmpl_cnt <= cmpl_next;
                    if (cmpl_next == total) begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_o    <= 1'b0;
                    idle_o    <= 1'b1;
                    issue_cnt <= '0;
                    cmpl_cnt  <= '0;
                    state     <= S_IDLE;
                end

                default: begin
                    state      <= S_IDLE;
                    op_valid_o <= 1'b0;
                    op_idx_o   <= '0;
                    idle_o     <= 1'b1;
                    done_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule
